// File: rtl/cvxif_instr_pkg.sv
// rtl/cvxif_instr_pkg.sv - shared issue kinds and result record for the group issuer
package cvxif_instr_pkg;

    localparam int unsigned X_ID_WIDTH  = 4;
    localparam int unsigned X_RES_WIDTH = 32;

    typedef enum logic [1:0] {
        ISSUE_FILL = 2'd0,
        ISSUE_EXEC = 2'd1,
        ISSUE_PICK = 2'd2,
        ISSUE_RSVD = 2'd3
    } issue_kind_e;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0]  id;
        logic [X_RES_WIDTH-1:0] data;
        logic                   err;
    } result_t;

endpackage

// File: rtl/fifo_v3.sv
// rtl/fifo_v3.sv - registered-output FIFO, power-of-two depth, pointers wrap naturally
module fifo_v3 #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    parameter type         dtype      = logic [DATA_WIDTH-1:0]
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH)-1:0] usage_o,
    input  dtype                     data_i,
    input  logic                     push_i,
    output dtype                     data_o,
    input  logic                     pop_i
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    dtype [DEPTH-1:0]  mem_q, mem_d;
    logic              do_push, do_pop;

    // usage_o reads zero when full; callers combine it with full_o
    assign full_o  = (cnt_q == (ADDR_W+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign usage_o = cnt_q[ADDR_W-1:0];
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        cnt_d = cnt_q + (ADDR_W+1)'(do_push) - (ADDR_W+1)'(do_pop);
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            mem_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/group_issuer.sv
// rtl/group_issuer.sv - issues FILL/EXEC/PICK to the accelerator groups with credit-guarded result FIFO
module group_issuer
    import cvxif_instr_pkg::*;
#(
    parameter int unsigned NUM_GROUP = 4,
    parameter int unsigned RES_DEPTH = 4,
    parameter int unsigned IN_W      = 32,
    parameter int unsigned OUT_W     = 32,
    parameter int unsigned OPC_W     = 4,
    parameter int unsigned IN_IDX_W  = 3,
    parameter int unsigned OUT_IDX_W = 3,
    parameter int unsigned ID_W      = X_ID_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 issue_valid_i,
    output logic                 issue_ready_o,
    input  logic [1:0]           issue_kind_i,
    input  logic [OPC_W-1:0]     issue_opcode_i,
    input  logic [ID_W-1:0]      issue_id_i,
    input  logic [IN_IDX_W-1:0]  issue_in_idx_i,
    input  logic [2*IN_W-1:0]    issue_in_data_i,
    input  logic [OUT_IDX_W-1:0] issue_out_idx_i,
    output logic                 grp_exec_o,
    output logic                 grp_in_vld_o,
    output logic                 grp_out_vld_o,
    output logic [OPC_W-1:0]     grp_opcode_o,
    output logic [ID_W-1:0]      grp_id_o,
    output logic [IN_IDX_W-1:0]  grp_in_idx_o,
    output logic [2*IN_W-1:0]    grp_in_data_o,
    output logic [OUT_IDX_W-1:0] grp_out_idx_o,
    input  logic                 grp_busy_i,
    input  logic                 grp_invalid_i,
    input  logic                 grp_done_i,
    input  logic [OUT_W-1:0]     grp_data_i,
    input  logic [ID_W-1:0]      grp_id_i,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [ID_W-1:0]      res_id_o,
    output logic [OUT_W-1:0]     res_data_o,
    output logic                 res_err_o
);

    localparam int unsigned CNT_W = $clog2(RES_DEPTH) + 1;

    if (NUM_GROUP == 0 || RES_DEPTH < 2 || (RES_DEPTH & (RES_DEPTH - 1)) != 0 ||
        OUT_W != X_RES_WIDTH || ID_W != X_ID_WIDTH) begin : g_bad_cfg
        $error("group_issuer: unsupported parameter set");
    end

    logic             is_err, needs_credit, credit_ok, accept;
    logic             fill_acc, exec_acc, pick_acc;
    logic [CNT_W-1:0] outstanding_q, outstanding_d, occupancy;
    logic [CNT_W:0]   credits_used;
    logic             fifo_full, fifo_empty, push, pop;
    logic [CNT_W-2:0] fifo_usage;
    result_t          push_data, pop_data;

    // every EXEC in flight owns a FIFO slot, so a done can never find the FIFO full
    assign occupancy    = {fifo_full, fifo_usage};
    assign credits_used = {1'b0, occupancy} + {1'b0, outstanding_q};

    always_comb begin
        is_err        = grp_invalid_i || (issue_kind_i == ISSUE_RSVD);
        needs_credit  = is_err || (issue_kind_i != ISSUE_FILL);
        credit_ok     = !needs_credit || (credits_used < (CNT_W+1)'(RES_DEPTH));
        // an error result would collide with the done push, so it waits a cycle
        issue_ready_o = !grp_busy_i && credit_ok && !(is_err && grp_done_i);
        accept        = issue_valid_i && issue_ready_o;
        fill_acc      = accept && !is_err && (issue_kind_i == ISSUE_FILL);
        exec_acc      = accept && !is_err && (issue_kind_i == ISSUE_EXEC);
        pick_acc      = accept && !is_err && (issue_kind_i == ISSUE_PICK);
    end

    always_comb begin
        grp_in_vld_o  = fill_acc;
        grp_exec_o    = exec_acc;
        grp_out_vld_o = pick_acc;
        grp_opcode_o  = issue_opcode_i;
        grp_id_o      = issue_id_i;
        grp_in_idx_o  = issue_in_idx_i;
        grp_in_data_o = issue_in_data_i;
        grp_out_idx_o = issue_out_idx_i;
    end

    always_comb begin
        push      = 1'b0;
        push_data = '0;
        if (grp_done_i) begin
            push      = 1'b1;
            push_data = '{id: grp_id_i, data: grp_data_i, err: 1'b0};
        end else if (accept && is_err) begin
            push      = 1'b1;
            push_data = '{id: issue_id_i, data: '0, err: 1'b1};
        end else if (pick_acc) begin
            push      = 1'b1;
            push_data = '{id: issue_id_i, data: grp_data_i, err: 1'b0};
        end
    end

    assign outstanding_d = outstanding_q + CNT_W'(exec_acc) - CNT_W'(grp_done_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

    assign pop = res_valid_o && res_ready_i;

    fifo_v3 #(
        .DEPTH (RES_DEPTH),
        .dtype (result_t)
    ) u_res_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (1'b0),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .usage_o (fifo_usage),
        .data_i  (push_data),
        .push_i  (push),
        .data_o  (pop_data),
        .pop_i   (pop)
    );

    assign res_valid_o = !fifo_empty;
    assign res_id_o    = pop_data.id;
    assign res_data_o  = pop_data.data;
    assign res_err_o   = pop_data.err;

    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(grp_done_i && (outstanding_q == '0)));
    a_single_push: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(grp_done_i && (pick_acc || (accept && is_err))));
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && fifo_full));

endmodule

// File: tb/tb_group_issuer.sv
// tb/tb_group_issuer.sv - vector table, directed corner sequences and random run against a queue model
module tb_group_issuer;
    import cvxif_instr_pkg::*;

    localparam int IN_W = 32, OUT_W = 32, OPC_W = 4, IN_IDX_W = 3, OUT_IDX_W = 3;
    localparam int ID_W = X_ID_WIDTH, DEPTH = 4;

    logic                 clk_i = 1'b0, rst_ni = 1'b0;
    logic                 issue_valid_i, issue_ready_o;
    logic [1:0]           issue_kind_i;
    logic [OPC_W-1:0]     issue_opcode_i;
    logic [ID_W-1:0]      issue_id_i;
    logic [IN_IDX_W-1:0]  issue_in_idx_i;
    logic [2*IN_W-1:0]    issue_in_data_i;
    logic [OUT_IDX_W-1:0] issue_out_idx_i;
    logic                 grp_exec_o, grp_in_vld_o, grp_out_vld_o;
    logic [OPC_W-1:0]     grp_opcode_o;
    logic [ID_W-1:0]      grp_id_o;
    logic [IN_IDX_W-1:0]  grp_in_idx_o;
    logic [2*IN_W-1:0]    grp_in_data_o;
    logic [OUT_IDX_W-1:0] grp_out_idx_o;
    logic                 grp_busy_i, grp_invalid_i, grp_done_i;
    logic [OUT_W-1:0]     grp_data_i;
    logic [ID_W-1:0]      grp_id_i;
    logic                 res_valid_o, res_ready_i;
    logic [ID_W-1:0]      res_id_o;
    logic [OUT_W-1:0]     res_data_o;
    logic                 res_err_o;

    group_issuer #(.NUM_GROUP(4), .RES_DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_kind_i(issue_kind_i), .issue_opcode_i(issue_opcode_i), .issue_id_i(issue_id_i),
        .issue_in_idx_i(issue_in_idx_i), .issue_in_data_i(issue_in_data_i),
        .issue_out_idx_i(issue_out_idx_i),
        .grp_exec_o(grp_exec_o), .grp_in_vld_o(grp_in_vld_o), .grp_out_vld_o(grp_out_vld_o),
        .grp_opcode_o(grp_opcode_o), .grp_id_o(grp_id_o), .grp_in_idx_o(grp_in_idx_o),
        .grp_in_data_o(grp_in_data_o), .grp_out_idx_o(grp_out_idx_o),
        .grp_busy_i(grp_busy_i), .grp_invalid_i(grp_invalid_i), .grp_done_i(grp_done_i),
        .grp_data_i(grp_data_i), .grp_id_i(grp_id_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_id_o(res_id_o),
        .res_data_o(res_data_o), .res_err_o(res_err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        issue_valid_i = 1'b0; issue_kind_i = 2'd0; issue_opcode_i = '0; issue_id_i = '0;
        issue_in_idx_i = '0; issue_in_data_i = '0; issue_out_idx_i = '0;
        grp_busy_i = 1'b0; grp_invalid_i = 1'b0; grp_done_i = 1'b0;
        grp_data_i = '0; grp_id_i = '0; res_ready_i = 1'b0;
    endtask

    task automatic issue(input logic [1:0] kind, input logic [OPC_W-1:0] opc, input logic [ID_W-1:0] id);
        issue_valid_i = 1'b1; issue_kind_i = kind; issue_opcode_i = opc; issue_id_i = id;
    endtask

    function automatic logic [2:0] strobes();
        return {grp_in_vld_o, grp_exec_o, grp_out_vld_o};
    endfunction

    function automatic logic [63:0] res_now();
        return 64'({res_id_o, res_data_o, res_err_o});
    endfunction

    function automatic logic [63:0] rec(input logic [ID_W-1:0] id, input logic [OUT_W-1:0] d, input logic e);
        return 64'({id, d, e});
    endfunction

    typedef struct packed {
        logic       valid;
        logic [1:0] kind;
        logic       busy, inv, done;
        logic       rdy;
        logic [2:0] strb;
    } vec_t;

    vec_t vecs [12];
    logic [ID_W+OUT_W:0] exp_q [$];
    int                  outst;
    logic [1:0]          rk;
    logic                rerr, rneed, rrdy, racc;
    logic [2:0]          rstrb;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b100};
        vecs[1]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010};
        vecs[2]  = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001};
        vecs[3]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000};
        vecs[4]  = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000};
        vecs[5]  = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000};
        vecs[6]  = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000};
        vecs[7]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000};
        vecs[8]  = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b100};
        vecs[9]  = '{1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000};
        vecs[10] = '{1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000};
        vecs[11] = '{1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000};

        // table runs while reset is held: ready must follow the rules with zero credits used
        idle();
        tick();
        for (int i = 0; i < 12; i++) begin
            issue_valid_i = vecs[i].valid; issue_kind_i = vecs[i].kind;
            grp_busy_i = vecs[i].busy; grp_invalid_i = vecs[i].inv; grp_done_i = vecs[i].done;
            issue_opcode_i = OPC_W'(i); issue_id_i = ID_W'(15 - i);
            issue_in_idx_i = IN_IDX_W'(i); issue_out_idx_i = OUT_IDX_W'(7 - i);
            issue_in_data_i = {$urandom, $urandom};
            #1;
            chk($sformatf("vec%0d_ready", i), 64'(issue_ready_o), 64'(vecs[i].rdy));
            chk($sformatf("vec%0d_strobe", i), 64'(strobes()), 64'(vecs[i].strb));
            chk($sformatf("vec%0d_res_valid", i), 64'(res_valid_o), 64'd0);
            chk($sformatf("vec%0d_copy", i), 64'({grp_opcode_o, grp_id_o, grp_in_idx_o, grp_out_idx_o}),
                64'({OPC_W'(i), ID_W'(15 - i), IN_IDX_W'(i), OUT_IDX_W'(7 - i)}));
            chk($sformatf("vec%0d_data_copy", i), grp_in_data_o, issue_in_data_i);
            tick();
        end
        idle();
        rst_ni = 1'b1;
        tick();

        // FILL: same-cycle strobe, no result
        issue(ISSUE_FILL, 4'd1, 4'd2); #1;
        chk("fill_strobe", 64'(strobes()), 64'b100);
        tick(); idle(); #1;
        chk("fill_no_result", 64'(res_valid_o), 64'd0);

        // EXEC id 5, done three cycles after acceptance
        issue(ISSUE_EXEC, 4'd2, 4'd5); #1;
        chk("exec_strobe", 64'(strobes()), 64'b010);
        tick(); idle(); tick(); tick();
        grp_done_i = 1'b1; grp_id_i = 4'd5; grp_data_i = 32'hABCD; #1;
        chk("exec_no_early_result", 64'(res_valid_o), 64'd0);
        tick(); idle(); #1;
        chk("exec_res_valid", 64'(res_valid_o), 64'd1);
        chk("exec_res", res_now(), rec(4'd5, 32'hABCD, 1'b0));
        res_ready_i = 1'b1; tick(); idle(); #1;
        chk("exec_popped", 64'(res_valid_o), 64'd0);

        // PICK returns group data tagged with the issue id
        issue(ISSUE_PICK, 4'd3, 4'd7); grp_data_i = 32'h1234; #1;
        chk("pick_strobe", 64'(strobes()), 64'b001);
        tick(); idle(); #1;
        chk("pick_res", res_now(), rec(4'd7, 32'h1234, 1'b0));
        res_ready_i = 1'b1; tick(); idle();

        // error issue colliding with done stalls one cycle
        issue(ISSUE_EXEC, 4'd0, 4'd3); tick(); idle();
        issue(ISSUE_EXEC, 4'd9, 4'd6); grp_invalid_i = 1'b1;
        grp_done_i = 1'b1; grp_id_i = 4'd3; grp_data_i = 32'h55; #1;
        chk("err_stall_ready", 64'(issue_ready_o), 64'd0);
        chk("err_stall_strobe", 64'(strobes()), 64'b000);
        tick(); grp_done_i = 1'b0; #1;
        chk("err_retry_ready", 64'(issue_ready_o), 64'd1);
        chk("err_retry_strobe", 64'(strobes()), 64'b000);
        chk("err_done_res", res_now(), rec(4'd3, 32'h55, 1'b0));
        tick(); idle(); res_ready_i = 1'b1; #1;
        chk("err_head_still_done", res_now(), rec(4'd3, 32'h55, 1'b0));
        tick(); #1;
        chk("err_res", res_now(), rec(4'd6, 32'h0, 1'b1));
        chk("err_res_valid", 64'(res_valid_o), 64'd1);
        tick(); idle(); #1;
        chk("err_drained", 64'(res_valid_o), 64'd0);

        // credit exhaustion at RES_DEPTH
        for (int i = 0; i < 4; i++) begin
            issue(ISSUE_EXEC, OPC_W'(i), ID_W'(8 + i)); #1;
            chk($sformatf("depth_exec%0d_ready", i), 64'(issue_ready_o), 64'd1);
            tick();
        end
        issue(ISSUE_EXEC, 4'd0, 4'd12); #1;
        chk("depth_fifth_exec_ready", 64'(issue_ready_o), 64'd0);
        chk("depth_fifth_strobe", 64'(strobes()), 64'b000);
        issue_kind_i = ISSUE_PICK; #1;
        chk("depth_pick_ready", 64'(issue_ready_o), 64'd0);
        issue_kind_i = ISSUE_FILL; #1;
        chk("depth_fill_ready", 64'(issue_ready_o), 64'd1);
        issue_kind_i = ISSUE_EXEC;
        for (int i = 0; i < 4; i++) begin
            grp_done_i = 1'b1; grp_id_i = ID_W'(8 + i); grp_data_i = 32'(100 + i); #1;
            chk($sformatf("depth_done%0d_ready", i), 64'(issue_ready_o), 64'd0);
            tick();
        end
        grp_done_i = 1'b0; #1;
        chk("depth_full_head", res_now(), rec(4'd8, 32'd100, 1'b0));
        res_ready_i = 1'b1; #1;
        chk("depth_same_cycle_pop_ready", 64'(issue_ready_o), 64'd0);
        tick(); issue_valid_i = 1'b0; res_ready_i = 1'b0; #1;
        chk("depth_after_pop_ready", 64'(issue_ready_o), 64'd1);
        for (int i = 1; i < 4; i++) begin
            chk($sformatf("depth_order%0d", i), res_now(), rec(ID_W'(8 + i), 32'(100 + i), 1'b0));
            res_ready_i = 1'b1; tick(); res_ready_i = 1'b0; #1;
        end
        chk("depth_drained", 64'(res_valid_o), 64'd0);

        // mid-operation reset drops results and restores credits
        idle();
        for (int i = 0; i < 3; i++) begin
            issue(ISSUE_EXEC, 4'd1, ID_W'(1 + i)); tick();
        end
        idle(); grp_done_i = 1'b1; grp_id_i = 4'd1; grp_data_i = 32'h77; tick(); idle(); #1;
        chk("rst_pre_valid", 64'(res_valid_o), 64'd1);
        rst_ni = 1'b0; #1;
        chk("rst_valid_low", 64'(res_valid_o), 64'd0);
        tick(); rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(ISSUE_EXEC, 4'd2, ID_W'(i)); #1;
            chk($sformatf("rst_exec%0d_ready", i), 64'(issue_ready_o), 64'd1);
            tick();
        end
        idle(); #1;
        chk("rst_no_stale_result", 64'(res_valid_o), 64'd0);
        rst_ni = 1'b0; tick(); rst_ni = 1'b1;

        // random traffic against a queue-level model
        exp_q.delete();
        outst = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            issue_valid_i = ($urandom_range(0, 3) != 0);
            rk = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            issue_kind_i = rk;
            issue_opcode_i = OPC_W'($urandom); issue_id_i = ID_W'($urandom);
            issue_in_idx_i = IN_IDX_W'($urandom); issue_out_idx_i = OUT_IDX_W'($urandom);
            issue_in_data_i = {$urandom, $urandom};
            grp_busy_i = ($urandom_range(0, 7) == 0);
            grp_invalid_i = ($urandom_range(0, 9) == 0);
            grp_done_i = (outst > 0) && (rk != 2'd2) && ($urandom_range(0, 2) == 0);
            grp_id_i = ID_W'($urandom); grp_data_i = $urandom;
            res_ready_i = (cyc % 64 < 32) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);

            rerr = grp_invalid_i || (rk == 2'd3);
            rneed = rerr || (rk != 2'd0);
            rrdy = !grp_busy_i && (!rneed || (exp_q.size() + outst < DEPTH)) && !(rerr && grp_done_i);
            racc = issue_valid_i && rrdy;
            rstrb = (racc && !rerr) ? (3'b100 >> rk) : 3'b000;
            #1;
            chk("rnd_ready", 64'(issue_ready_o), 64'(rrdy));
            chk("rnd_strobe", 64'(strobes()), 64'(rstrb));
            chk("rnd_res_valid", 64'(res_valid_o), 64'(exp_q.size() > 0));
            if (exp_q.size() > 0) chk("rnd_res", res_now(), 64'(exp_q[0]));

            if (res_ready_i && exp_q.size() > 0) void'(exp_q.pop_front());
            if (grp_done_i) exp_q.push_back({grp_id_i, grp_data_i, 1'b0});
            else if (racc && rerr) exp_q.push_back({issue_id_i, 32'h0, 1'b1});
            else if (racc && rk == 2'd2) exp_q.push_back({issue_id_i, grp_data_i, 1'b0});
            outst = outst + int'(racc && !rerr && rk == 2'd1) - int'(grp_done_i);
            tick();
        end
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
